nibble_serial_adder: RTL and testbench

- Multi-word add sequencer that drives the team's 4-bit ripple carry adder one nibble per clock.
- Chains the carry between nibbles and assembles a NIBBLES*4-bit result with status flags.
- Sits directly upstream of the 4-bit adder, supplying operand nibbles and carry-in, and directly downstream of it, registering its sum and carry-out.
- Used as the datapath add unit for widths above 4 bits without duplicating adder hardware.

---
 rtl/nibble_serial_adder.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-word add sequencer: drives an external 4-bit adder one nibble per clock.
// Optional subtract mode under `NIBBLE_SERIAL_ADDER_SUB_EN` (adds input port sub).
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic [3:0]   nib_a,
    output logic [3:0]   nib_b,
    output logic         nib_cin,
    input  logic [3:0]   nib_sum,
    input  logic         nib_cout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero,
    output logic         overflow
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   opa, opb, res, res_nx, b_eff;
    logic           carry, cin_eff, a_msb, b_msb, last;
    logic [CW-1:0]  cnt;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last   = (cnt == CW'(NIBBLES - 1));
    assign res_nx = {nib_sum, res[W-1:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand MSBs are kept aside because the operand registers shift away during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_eff;
                        carry <= cin_eff;
                        cnt   <= '0;
                        a_msb <= a[W-1];
                        b_msb <= b_eff[W-1];
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= nib_cout;
                    opa   <= {4'b0000, opa[W-1:4]};
                    opb   <= {4'b0000, opb[W-1:4]};
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum      <= res_nx;
                        cout     <= nib_cout;
                        zero     <= (res_nx == '0);
                        overflow <= (a_msb == b_msb) && (nib_sum[3] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign nib_a   = busy ? opa[3:0] : 4'b0000;
    assign nib_b   = busy ? opb[3:0] : 4'b0000;
    assign nib_cin = busy & carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder.
// Exercises subtract mode when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n, start, cin, sub_r;
    logic [15:0] a, b, sum;
    logic [3:0]  nib_a, nib_b, nib_sum;
    logic        nib_cin, nib_cout, busy, done, cout, zero, overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_sum = '0;

    always #5 clk = ~clk;

    // Stand-in for the external 4-bit ripple adder.
    assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, nib_cin};

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub(sub_r),
`endif
        .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
        .nib_sum(nib_sum), .nib_cout(nib_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .zero(zero), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, z, ov;
        logic        chk_seq;
        logic [15:0] nseq;
        logic [3:0]  cseq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the effective operands.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] bb;
        logic [16:0] full;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + 17'(ms ? 1'b1 : mc);
        return {(ma[15] == bb[15]) && (full[15] != ma[15]), full[15:0] == 16'h0, full[16], full[15:0]};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic eco, input logic ez, input logic eov,
                          output logic [15:0] nseq, output logic [3:0] cseq);
        int   cyc, nb;
        logic held;
        a = ta; b = tbv; cin = tc; sub_r = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub_r = 1'($urandom);
        cyc = 1; nb = 0; held = 1'b1; nseq = '0; cseq = '0;
        while (!done && cyc < 20) begin
            if (busy) begin
                if (nb < 4) begin
                    nseq[nb*4 +: 4] = nib_a;
                    cseq[nb] = nib_cin;
                end
                nb++;
                if (sum !== last_sum) held = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_cycle"}, cyc, 5);
        check({tag, " busy_cycles"}, nb, 4);
        check({tag, " sum_held_in_run"}, held, 1);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, eco);
        check({tag, " zero"}, zero, ez);
        check({tag, " overflow"}, overflow, eov);
        check({tag, " nib_idle_in_done"}, {nib_a, nib_b, nib_cin}, 0);
        last_sum = es;
        @(negedge clk);
        check({tag, " done_one_cycle"}, {done, busy}, 0);
    endtask

    initial begin
        logic [15:0] nseq;
        logic [3:0]  cseq;
        logic [18:0] m;
        int          ndone, d1, d2, n;

        vecs.push_back('{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0001});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 4'b1110});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0});
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0});
`endif

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, sum, cout, zero, overflow, nib_a, nib_b, nib_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, nib_a, nib_b, nib_cin}, 0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].s, vecs[i].co, vecs[i].z, vecs[i].ov, nseq, cseq);
            if (vecs[i].chk_seq) begin
                check($sformatf("vec%0d nib_a_seq", i), nseq, vecs[i].nseq);
                check($sformatf("vec%0d nib_cin_seq", i), cseq, vecs[i].cseq);
            end
        end

        for (int i = 0; i < 25; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs, m[15:0], m[16], m[17], m[18], nseq, cseq);
        end

        // start held for ten edges; operands disturbed mid-RUN
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub_r = 1'b0; start = 1'b1;
        ndone = 0; d1 = 0; d2 = 0;
        for (n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = n; else d2 = n;
                check($sformatf("hold_sum_c%0d", n), sum, 16'h0003);
            end
            start = (n < 10);
            a = (n == 2 || n == 3 || n == 8 || n == 9) ? 16'hAAAA : 16'h0001;
            b = (n == 2 || n == 3 || n == 8 || n == 9) ? 16'hAAAA : 16'h0002;
        end
        check("hold_done_count", ndone, 2);
        check("hold_first_done", d1, 5);
        check("hold_second_done", d2, 11);
        last_sum = 16'h0003;

        // reset in the second RUN cycle
        a = 16'h1234; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrun_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy, done, sum, cout, zero, overflow, nib_a, nib_b, nib_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = '0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrun_no_done", ndone, 0);
        run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, nseq, cseq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
